// File: rtl/bnn_buf_pkg.sv
// Shared types and helpers for the binarized-pixel window shift buffer.
//   buf_state_e       : FILL / FULL control state.
//   fill_level_width  : width of the fill_level counter for a given window depth.
package bnn_buf_pkg;

  typedef enum logic {StFill, StFull} buf_state_e;

  // Enough bits to count 0..depth inclusive.
  function automatic int unsigned fill_level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bnn_stride_ctr.sv
// Stride phase counter for the window shift buffer.
// Counts accepted columns modulo STRIDE once the window is full.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   clear      : force phase to 0 (priority over advance)
//   advance    : one accepted column while full
//   wrap       : advance this cycle takes the phase back to 0
module bnn_stride_ctr #(
  parameter int unsigned STRIDE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic advance,
  output logic wrap
);

  localparam int unsigned PhaseW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [PhaseW-1:0] LastPhase = PhaseW'(STRIDE - 1);

  logic [PhaseW-1:0] phase_q, phase_d;

  // With STRIDE == 1 the phase is pinned at 0, so every advance wraps.
  assign wrap = advance && (phase_q == LastPhase);

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (advance) begin
      phase_d = wrap ? '0 : phase_q + PhaseW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/window_shift_buffer.sv
// Sliding window over a stream of binarized pixel columns.
// Holds the last DEPTH columns and emits a window every STRIDE columns once full.
// Optional build macro: WINDOW_SHIFT_BUFFER_CLEAR_ON_FLUSH_EN -- flush also zeroes the columns.
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   flush               : drop the current window and restart filling
//   in_valid, in_ready  : column input handshake; data_in is the column
//   out_valid, out_ready: window output handshake; data_out = {col[DEPTH-1], ..., col[0]}
//   fill_level          : valid columns held, saturating at DEPTH
module window_shift_buffer
  import bnn_buf_pkg::*;
#(
  parameter int unsigned COL_W  = 5,
  parameter int unsigned DEPTH  = 5,
  parameter int unsigned STRIDE = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic                                 in_valid,
  input  logic [COL_W-1:0]                     data_in,
  output logic                                 in_ready,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [COL_W*DEPTH-1:0]               data_out,
  output logic [fill_level_width(DEPTH)-1:0]   fill_level
);

  localparam int unsigned FillW = fill_level_width(DEPTH);
  localparam int unsigned WinW  = COL_W * DEPTH;
  localparam logic [FillW-1:0] LastFill = FillW'(DEPTH - 1);

  buf_state_e        state_q, state_d;
  logic [FillW-1:0]  fill_q, fill_d;
  logic [WinW-1:0]   window_q, window_d;
  logic              out_valid_q, out_valid_d;

  logic col_take;
  logic fill_to_full;
  logic take_full;
  logic wrap;
  logic emit;

  // Stall only while a window is pending and the consumer is not taking it.
  assign in_ready = !(out_valid_q && !out_ready);

  // A column coinciding with flush is dropped.
  assign col_take = in_valid && in_ready && !flush;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StFill;
    end else begin
      unique case (state_q)
        StFill:  if (col_take && (fill_q == LastFill)) state_d = StFull;
        StFull:  state_d = StFull;
        default: state_d = StFill;
      endcase
    end
  end

  // Decoded control outputs of the FSM.
  always_comb begin
    fill_to_full = 1'b0;
    take_full    = 1'b0;
    unique case (state_q)
      StFill:  fill_to_full = col_take && (fill_q == LastFill);
      StFull:  take_full    = col_take;
      default: ;
    endcase
  end

  bnn_stride_ctr #(
    .STRIDE (STRIDE)
  ) u_stride_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (flush || fill_to_full),
    .advance (take_full),
    .wrap    (wrap)
  );

  assign emit = fill_to_full || (take_full && wrap);

  always_comb begin
    fill_d      = fill_q;
    window_d    = window_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      fill_d      = '0;
      out_valid_d = 1'b0;
`ifdef WINDOW_SHIFT_BUFFER_CLEAR_ON_FLUSH_EN
      window_d    = '0;
`endif
    end else begin
      if (col_take) begin
        // Newest column enters at the MSB end; oldest falls off the LSB end.
        window_d = {data_in, window_q[WinW-1:COL_W]};
        if (state_q == StFill) fill_d = fill_q + FillW'(1);
      end
      if (emit) begin
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q      <= '0;
      window_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      window_q    <= window_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign data_out   = window_q;
  assign fill_level = fill_q;

endmodule

// File: tb/tb_window_shift_buffer.sv
// Directed bench for window_shift_buffer: one STRIDE=1 instance and one STRIDE=2 instance.
module tb_window_shift_buffer;

  localparam int unsigned ColW  = 5;
  localparam int unsigned Depth = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: STRIDE = 1
  logic             a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [ColW-1:0]  a_data_in;
  logic [24:0]      a_data_out;
  logic [2:0]       a_fill;

  // Instance B: STRIDE = 2
  logic             b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [ColW-1:0]  b_data_in;
  logic [24:0]      b_data_out;
  logic [2:0]       b_fill;

  window_shift_buffer #(.COL_W(ColW), .DEPTH(Depth), .STRIDE(1)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (a_flush),
    .in_valid   (a_in_valid),
    .data_in    (a_data_in),
    .in_ready   (a_in_ready),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .data_out   (a_data_out),
    .fill_level (a_fill)
  );

  window_shift_buffer #(.COL_W(ColW), .DEPTH(Depth), .STRIDE(2)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (b_flush),
    .in_valid   (b_in_valid),
    .data_in    (b_data_in),
    .in_ready   (b_in_ready),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .data_out   (b_data_out),
    .fill_level (b_fill)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] win(input int c4, input int c3, input int c2, input int c1,
                                      input int c0);
    return {5'(c4), 5'(c3), 5'(c2), 5'(c1), 5'(c0)};
  endfunction

  // Drive one column on A and advance to the next sampling point.
  task automatic push_a(input int v);
    a_in_valid = 1'b1;
    a_data_in  = 5'(v);
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [24:0] expected_after_flush;

  initial begin
    rst_n       = 1'b0;
    a_flush     = 1'b0; a_in_valid = 1'b0; a_data_in = '0; a_out_ready = 1'b1;
    b_flush     = 1'b0; b_in_valid = 1'b0; b_data_in = '0; b_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_fill", 32'(a_fill), 0);
    chk("rst_out_valid", 32'(a_out_valid), 0);
    chk("rst_in_ready", 32'(a_in_ready), 1);
    chk("rst_data_out", 32'(a_data_out), 0);
    rst_n = 1'b1;

    // Basic fill with STRIDE=1
    push_a(1); push_a(2); push_a(3);
    chk("fill_after3", 32'(a_fill), 3);
    push_a(4);
    chk("no_window_after4", 32'(a_out_valid), 0);
    push_a(5);
    chk("window1_valid", 32'(a_out_valid), 1);
    chk("window1_data", 32'(a_data_out), 32'(win(5, 4, 3, 2, 1)));
    chk("fill_saturated", 32'(a_fill), 5);
    push_a(6);
    chk("window2_valid", 32'(a_out_valid), 1);
    chk("window2_data", 32'(a_data_out), 32'(win(6, 5, 4, 3, 2)));
    chk("fill_still_saturated", 32'(a_fill), 5);
    @(negedge clk);
    chk("window2_consumed", 32'(a_out_valid), 0);

    // Backpressure
    reset_all();
    a_out_ready = 1'b0;
    push_a(1); push_a(2); push_a(3); push_a(4);
    chk("bp_ready_before_window", 32'(a_in_ready), 1);
    push_a(5);
    chk("bp_window_valid", 32'(a_out_valid), 1);
    a_in_valid = 1'b1;
    a_data_in  = 5'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_stall_ready_%0d", i), 32'(a_in_ready), 0);
      chk($sformatf("bp_hold_data_%0d", i), 32'(a_data_out), 32'(win(5, 4, 3, 2, 1)));
    end
    chk("bp_hold_valid", 32'(a_out_valid), 1);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(a_in_ready), 1);
    @(negedge clk);
    chk("bp_released_valid", 32'(a_out_valid), 0);
    chk("bp_released_ready", 32'(a_in_ready), 1);

    // Reset while a window is pending
    a_out_ready = 1'b0;
    push_a(6);
    chk("pend_valid", 32'(a_out_valid), 1);
    chk("pend_data", 32'(a_data_out), 32'(win(6, 5, 4, 3, 2)));
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(a_out_valid), 0);
    chk("mid_rst_fill", 32'(a_fill), 0);
    chk("mid_rst_ready", 32'(a_in_ready), 1);
    chk("mid_rst_data", 32'(a_data_out), 0);
    rst_n = 1'b1;
    a_out_ready = 1'b1;

    // Flush together with an offered column
    push_a(1); push_a(2); push_a(3);
    a_flush    = 1'b1;
    a_in_valid = 1'b1;
    a_data_in  = 5'd4;
    @(negedge clk);
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    chk("flush_fill", 32'(a_fill), 0);
    chk("flush_valid", 32'(a_out_valid), 0);
`ifdef WINDOW_SHIFT_BUFFER_CLEAR_ON_FLUSH_EN
    expected_after_flush = '0;
`else
    expected_after_flush = win(3, 2, 1, 0, 0);
`endif
    chk("flush_columns", 32'(dut_a.window_q), 32'(expected_after_flush));
    push_a(10); push_a(11); push_a(12); push_a(13);
    chk("post_flush_no_window", 32'(a_out_valid), 0);
    chk("post_flush_fill4", 32'(a_fill), 4);
    push_a(14);
    chk("post_flush_window", 32'(a_out_valid), 1);
    chk("post_flush_data", 32'(a_data_out), 32'(win(14, 13, 12, 11, 10)));

    // STRIDE=2 on instance B: windows end at columns 5, 7 and 9
    for (int v = 1; v <= 9; v++) begin
      b_in_valid = 1'b1;
      b_data_in  = 5'(v);
      @(negedge clk);
      chk($sformatf("stride2_valid_col%0d", v), 32'(b_out_valid),
          32'((v == 5) || (v == 7) || (v == 9)));
    end
    b_in_valid = 1'b0;
    chk("stride2_last_data", 32'(b_data_out), 32'(win(9, 8, 7, 6, 5)));
    @(negedge clk);
    chk("stride2_drained", 32'(b_out_valid), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
